// File: rtl/adc_pkg.sv
// adc_pkg: controller states and default word/channel widths for the SAR ADC serial-read path.
package adc_pkg;
    localparam int W_DATA_DEF = 16;
    localparam int W_CHS_DEF  = 3;
    typedef enum logic [2:0] {ST_IDLE, ST_CONVST, ST_BUSY_WAIT, ST_RX, ST_DONE} state_t;
endpackage

// File: rtl/adc_spi_rx.sv
// adc_spi_rx: SCLK divider, rising-edge sampler and MSB-first word shifter; flags each completed word.
module adc_spi_rx
    import adc_pkg::*;
#(
    parameter int W_DATA   = W_DATA_DEF,
    parameter int SCLK_DIV = 2
) (
    input  logic              clk_in,
    input  logic              nreset_in,
    input  logic              en_i,
    input  logic              dout_in,
    output logic              sclk_out,
    output logic              word_done_o,
    output logic [W_DATA-1:0] word_o
);
    localparam int W_DIV = SCLK_DIV > 1 ? $clog2(SCLK_DIV) : 1;
    localparam int W_BIT = $clog2(W_DATA);
    logic [W_DIV-1:0]  div_q, div_d;
    logic [W_BIT-1:0]  bit_q, bit_d;
    logic [W_DATA-2:0] shift_q, shift_d;
    logic              sclk_q, sclk_d;
    logic              toggle, rise;
    // The final sample bypasses the shifter so the word is ready on the same edge.
    always_comb begin
        toggle      = en_i && div_q == W_DIV'(SCLK_DIV - 1);
        rise        = toggle && !sclk_q;
        div_d       = (!en_i || toggle) ? '0 : div_q + 1'b1;
        sclk_d      = !en_i ? 1'b1 : sclk_q ^ toggle;
        word_o      = {shift_q, dout_in};
        shift_d     = rise ? word_o[W_DATA-2:0] : shift_q;
        word_done_o = rise && bit_q == W_BIT'(W_DATA - 1);
        bit_d       = !en_i ? '0 : !rise ? bit_q : word_done_o ? '0 : bit_q + 1'b1;
    end
    always_ff @(posedge clk_in or negedge nreset_in) begin
        if (!nreset_in) begin
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b1;
        end else begin
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
        end
    end
    assign sclk_out = sclk_q;
endmodule

// File: rtl/adc_controller.sv
// adc_controller: conversion start, busy handshake and N_CHAN-word serial readout for the SAR ADC.
// Define ADC_BUSY_TIMEOUT_EN to add the busy watchdog and its timeout_out pulse.
module adc_controller
    import adc_pkg::*;
#(
    parameter int W_DATA     = W_DATA_DEF,
    parameter int W_CHS      = W_CHS_DEF,
    parameter int N_CHAN     = 8,
    parameter int SCLK_DIV   = 2,
`ifdef ADC_BUSY_TIMEOUT_EN
    parameter int T_BUSY_MAX = 1024,
`endif
    parameter int T_CONVST   = 4
) (
    input  logic              clk_in,
    input  logic              nreset_in,
    input  logic              cstart_in,
    input  logic              busy_in,
    input  logic              dout_in,
    output logic              convst_out,
    output logic              ncs_out,
    output logic              sclk_out,
    output logic [W_DATA-1:0] data_out,
    output logic [W_CHS-1:0]  channel_out,
    output logic              data_valid_out,
`ifdef ADC_BUSY_TIMEOUT_EN
    output logic              timeout_out,
`endif
    output logic              cycle_done_out
);
    localparam int W_CNV = T_CONVST > 1 ? $clog2(T_CONVST) : 1;
    state_t            state_q, state_d;
    logic [W_CNV-1:0]  cnv_q, cnv_d;
    logic [W_CHS-1:0]  chan_q, chan_d, chout_q, chout_d;
    logic [W_DATA-1:0] data_q, data_d, word;
    logic              busy_meta_q, busy_sync_q, seen_q, seen_d, valid_q, word_done;
`ifdef ADC_BUSY_TIMEOUT_EN
    localparam int W_WD = T_BUSY_MAX > 1 ? $clog2(T_BUSY_MAX) : 1;
    logic [W_WD-1:0] wd_q, wd_d;
    logic            to_q, to_d;
`endif

    adc_spi_rx #(.W_DATA(W_DATA), .SCLK_DIV(SCLK_DIV)) u_rx (
        .clk_in     (clk_in),
        .nreset_in  (nreset_in),
        .en_i       (state_q == ST_RX),
        .dout_in    (dout_in),
        .sclk_out   (sclk_out),
        .word_done_o(word_done),
        .word_o     (word)
    );

    always_comb begin
        state_d = state_q;
        cnv_d   = '0;
        seen_d  = seen_q;
        chan_d  = chan_q;
        chout_d = chout_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: if (cstart_in) begin
                state_d = ST_CONVST;
                chan_d  = '0;
            end
            ST_CONVST: begin
                cnv_d   = cnv_q + 1'b1;
                seen_d  = 1'b0;
                state_d = cnv_q == W_CNV'(T_CONVST - 1) ? ST_BUSY_WAIT : ST_CONVST;
            end
            // Readout starts only after a full high-then-low busy pulse.
            ST_BUSY_WAIT: begin
                seen_d  = seen_q | busy_sync_q;
                state_d = (seen_q && !busy_sync_q) ? ST_RX : ST_BUSY_WAIT;
            end
            ST_RX: if (word_done) begin
                data_d  = word;
                chout_d = chan_q;
                chan_d  = chan_q + 1'b1;
                state_d = chan_q == W_CHS'(N_CHAN - 1) ? ST_DONE : ST_RX;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef ADC_BUSY_TIMEOUT_EN
        wd_d = state_q == ST_BUSY_WAIT ? wd_q + 1'b1 : '0;
        to_d = state_q == ST_BUSY_WAIT && wd_q == W_WD'(T_BUSY_MAX - 1);
        if (to_d) state_d = ST_IDLE;
`endif
    end

    always_ff @(posedge clk_in or negedge nreset_in) begin
        if (!nreset_in) begin
            state_q     <= ST_IDLE;
            cnv_q       <= '0;
            seen_q      <= 1'b0;
            chan_q      <= '0;
            chout_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_meta_q <= 1'b0;
            busy_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnv_q       <= cnv_d;
            seen_q      <= seen_d;
            chan_q      <= chan_d;
            chout_q     <= chout_d;
            data_q      <= data_d;
            valid_q     <= word_done;
            busy_meta_q <= busy_in;
            busy_sync_q <= busy_meta_q;
        end
    end

`ifdef ADC_BUSY_TIMEOUT_EN
    always_ff @(posedge clk_in or negedge nreset_in) begin
        if (!nreset_in) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end
    assign timeout_out = to_q;
`endif

    assign convst_out     = state_q != ST_CONVST;
    assign ncs_out        = state_q != ST_RX;
    assign cycle_done_out = state_q == ST_DONE;
    assign data_out       = data_q;
    assign channel_out    = chout_q;
    assign data_valid_out = valid_q;
endmodule

// File: tb/tb_adc_controller.sv
// tb_adc_controller: ADC behavioural model (busy pulse, MSB-first dout on SCLK fall) plus word scoreboard.
module tb_adc_controller;
    localparam int NC = 8;
    localparam int SD = 2;
    logic clk_in = 0, nreset_in = 0, cstart_in = 0, busy_in = 0, dout_in = 0;
    logic convst_out, ncs_out, sclk_out, data_valid_out, cycle_done_out;
    logic [15:0] data_out;
    logic [2:0] channel_out;
`ifdef ADC_BUSY_TIMEOUT_EN
    logic timeout_out;
`endif
    int checks = 0, failures = 0;
    int vcnt = 0, rises = 0, cnv_low = 0, rx_cycles = 0, bad_half = 0, low_run = 0;
    int busy_len = 20, bit_i = 0, ch_i = 0;
    bit busy_stuck = 0, sclk_prev = 1;
    logic [15:0] cur_w [NC];

    typedef struct { logic [15:0] w [NC]; int busy; int exp_valids; int exp_rises; } vec_t;
    vec_t tbl [4];

    adc_controller dut (
        .clk_in(clk_in), .nreset_in(nreset_in), .cstart_in(cstart_in), .busy_in(busy_in),
        .dout_in(dout_in), .convst_out(convst_out), .ncs_out(ncs_out), .sclk_out(sclk_out),
        .data_out(data_out), .channel_out(channel_out), .data_valid_out(data_valid_out),
`ifdef ADC_BUSY_TIMEOUT_EN
        .timeout_out(timeout_out),
`endif
        .cycle_done_out(cycle_done_out)
    );

    always #5 clk_in = ~clk_in;

    // ADC: busy rises shortly after CONVST ends, dout launches the next bit on every SCLK fall.
    always @(posedge convst_out) if (nreset_in === 1'b1) begin
        repeat (2) @(negedge clk_in);
        busy_in = 1;
        if (!busy_stuck) begin
            repeat (busy_len) @(negedge clk_in);
            busy_in = 0;
        end
    end
    always @(negedge ncs_out) begin bit_i = 0; ch_i = 0; end
    always @(negedge sclk_out) if (ncs_out === 1'b0 && ch_i < NC) begin
        dout_in = cur_w[ch_i][15 - bit_i];
        if (bit_i == 15) begin bit_i = 0; ch_i++; end else bit_i++;
    end

    // Scoreboard: k-th valid of a run must carry channel k mod N and that channel's word.
    always @(negedge clk_in) begin
        if (convst_out === 1'b0) cnv_low++;
        if (ncs_out === 1'b0) rx_cycles++;
        if (sclk_out && !sclk_prev) begin
            rises++;
            if (low_run != SD) bad_half++;
        end
        low_run = sclk_out ? 0 : low_run + 1;
        sclk_prev = sclk_out;
        if (data_valid_out === 1'b1) begin
            checks++;
            if (channel_out !== 3'(vcnt % NC) || data_out !== cur_w[vcnt % NC]) begin
                failures++;
                $display("FAIL word%0d: got ch=%0d data=%h expected ch=%0d data=%h",
                         vcnt, channel_out, data_out, vcnt % NC, cur_w[vcnt % NC]);
            end
            vcnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        vcnt = 0; rises = 0; cnv_low = 0; rx_cycles = 0; bad_half = 0;
    endtask

    task automatic start_cycle();
        clear_counts();
        @(negedge clk_in); cstart_in = 1;
        @(negedge clk_in); cstart_in = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (cycle_done_out !== 1'b1 && n < 3000) begin @(negedge clk_in); n++; end
        #1;
        chk({name, "_done_seen"}, int'(cycle_done_out === 1'b1), 1);
    endtask

    task automatic wait_vcnt(input int k);
        int n = 0;
        while (vcnt < k && n < 3000) begin @(negedge clk_in); n++; end
        chk("vcnt_reached", int'(vcnt >= k), 1);
    endtask

    task automatic full_cycle(input string name, input int exp_valids, input int exp_rises);
        start_cycle();
        wait_done(name);
        chk({name, "_valids"}, vcnt, exp_valids);
        chk({name, "_convst_low"}, cnv_low, 4);
        chk({name, "_sclk_rises"}, rises, exp_rises);
        chk({name, "_rx_cycles"}, rx_cycles, 2 * SD * exp_rises);
        chk({name, "_sclk_half"}, bad_half, 0);
        chk({name, "_ncs_done"}, int'(ncs_out), 1);
        chk({name, "_sclk_idle"}, int'(sclk_out), 1);
        @(negedge clk_in);
        chk({name, "_done_pulse"}, int'(cycle_done_out), 0);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            tbl[0].w[i] = 16'hA5A5 + 16'(i);
            tbl[1].w[i] = (i == 0) ? 16'h0000 : (i == NC - 1) ? 16'hFFFF : 16'h1234 * 16'(i);
            tbl[2].w[i] = 16'h8001;
            tbl[3].w[i] = (i == 0) ? 16'hFFFF : (i == NC - 1) ? 16'h0000 : 16'h5A5A ^ 16'(i);
        end
        for (int t = 0; t < 4; t++) begin
            tbl[t].busy = 20 - 5 * t;
            tbl[t].exp_valids = NC;
            tbl[t].exp_rises = NC * 16;
        end

        repeat (3) @(negedge clk_in);
        chk("rst_convst", int'(convst_out), 1);
        chk("rst_ncs", int'(ncs_out), 1);
        chk("rst_sclk", int'(sclk_out), 1);
        chk("rst_data", int'(data_out), 0);
        chk("rst_chan", int'(channel_out), 0);
        chk("rst_valid", int'(data_valid_out), 0);
        chk("rst_done", int'(cycle_done_out), 0);
        nreset_in = 1;

        for (int t = 0; t < 4; t++) begin
            cur_w = tbl[t].w;
            busy_len = tbl[t].busy;
            full_cycle($sformatf("tbl%0d", t), tbl[t].exp_valids, tbl[t].exp_rises);
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NC; i++) cur_w[i] = 16'($urandom);
            busy_len = $urandom_range(3, 40);
            full_cycle($sformatf("rnd%0d", r), NC, NC * 16);
        end

        // cstart held high: two back-to-back cycles, each preceded by one idle cycle.
        cur_w = tbl[0].w;
        busy_len = 20;
        clear_counts();
        @(negedge clk_in); cstart_in = 1;
        wait_done("b2b1");
        chk("b2b1_valids", vcnt, NC);
        @(negedge clk_in);
        chk("b2b_idle_gap", int'(convst_out), 1);
        @(negedge clk_in);
        chk("b2b_restart", int'(convst_out), 0);
        cstart_in = 0;
        wait_done("b2b2");
        chk("b2b2_valids", vcnt, 2 * NC);
        repeat (20) @(negedge clk_in);
        chk("b2b_no_third", cnv_low, 8);

        // cstart during readout and during DONE must not start another cycle.
        cur_w = tbl[3].w;
        start_cycle();
        wait_vcnt(2);
        cstart_in = 1;
        @(negedge clk_in); cstart_in = 0;
        wait_done("midrx");
        cstart_in = 1;
        @(negedge clk_in); cstart_in = 0;
        repeat (20) @(negedge clk_in);
        chk("midrx_valids", vcnt, NC);
        chk("midrx_no_extra", cnv_low, 4);
        chk("midrx_idle_ncs", int'(ncs_out), 1);

        // Asynchronous reset during channel 3, then a clean restart from channel 0.
        cur_w = tbl[0].w;
        start_cycle();
        wait_vcnt(3);
        repeat (10) @(negedge clk_in);
        #3 nreset_in = 0;
        #1;
        chk("arst_convst", int'(convst_out), 1);
        chk("arst_ncs", int'(ncs_out), 1);
        chk("arst_sclk", int'(sclk_out), 1);
        chk("arst_data", int'(data_out), 0);
        chk("arst_chan", int'(channel_out), 0);
        chk("arst_valid", int'(data_valid_out), 0);
        chk("arst_done", int'(cycle_done_out), 0);
        @(negedge clk_in); nreset_in = 1;
        repeat (30) @(negedge clk_in);
        busy_in = 0;
        cur_w = tbl[2].w;
        full_cycle("post_rst", NC, NC * 16);

`ifdef ADC_BUSY_TIMEOUT_EN
        begin
            int n = 0;
            bit seen = 0;
            busy_stuck = 1;
            start_cycle();
            while (!seen && n < 1300) begin
                @(negedge clk_in); n++;
                if (timeout_out === 1'b1) seen = 1;
                if (cycle_done_out === 1'b1) chk("to_no_done", 1, 0);
            end
            chk("to_pulse", int'(seen), 1);
            chk("to_latency_ok", int'(n > 1024 && n < 1040), 1);
            chk("to_no_valid", vcnt, 0);
            @(negedge clk_in);
            chk("to_one_cycle", int'(timeout_out), 0);
            busy_stuck = 0;
            busy_in = 0;
            repeat (5) @(negedge clk_in);
            full_cycle("after_to", NC, NC * 16);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
